// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the SG32 interrupt controller: sizes, reset mask,
// FSM state encoding and a one-hot helper.
package int_ctrl_pkg;

  localparam int N_IRQ = 32;
  localparam int VEC_W = 5;
  localparam logic [N_IRQ-1:0] MASK_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  // One-hot decode of a vector index.
  function automatic logic [N_IRQ-1:0] vec_onehot(input logic [VEC_W-1:0] idx);
    logic [N_IRQ-1:0] one;
    one = {{(N_IRQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: bit 0 has the highest priority.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [N_IRQ-1:0] bits,
  output logic             any,
  output logic [VEC_W-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (bits[i]) begin
        any = 1'b1;
        idx = VEC_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller for the SG32 core. Software interrupts and external
// IRQ rising edges collect in a pending register; the lowest-index enabled
// pending bit is offered to the core via int_req/int_vec until int_ack, and
// stays in service until iret.
// Handshake: int_req/int_vec are held stable from the cycle int_req rises
// until the cycle int_ack is sampled high; int_ack outside a request is ignored.
// Optional feature: define INT_NEST_EN to allow a higher-priority interrupt to
// preempt one in service (nested service); otherwise service is single level.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_int_set,
  input  logic [N_IRQ-1:0] sw_int_in,
  input  logic [N_IRQ-1:0] ext_irq,
  input  logic             iret,
  input  logic             mask_wr_en,
  input  logic [N_IRQ-1:0] mask_wr_data,
  input  logic             int_ack,
  output logic             int_req,
  output logic [VEC_W-1:0] int_vec,
  output logic [N_IRQ-1:0] pending_out,
  output logic [N_IRQ-1:0] in_service,
  output logic [N_IRQ-1:0] mask_out
);

  state_t           state, state_nxt;
  logic [N_IRQ-1:0] pending, in_svc, mask, irq_q;
  logic [VEC_W-1:0] vec_q;

  logic [N_IRQ-1:0] eligible, set_vec, clr_vec, svc_after_iret;
  logic             win_any, svc_any, ack_fire, iret_fire, preempt, latch_vec;
  logic [VEC_W-1:0] win_idx, svc_idx;

  assign eligible = pending & mask;

  int_prio_enc u_win_enc (
    .bits (eligible),
    .any  (win_any),
    .idx  (win_idx)
  );

  int_prio_enc u_svc_enc (
    .bits (in_svc),
    .any  (svc_any),
    .idx  (svc_idx)
  );

  assign ack_fire       = (state == ST_REQ) && int_ack;
  assign iret_fire      = (state == ST_SERVICE) && iret && svc_any;
  assign svc_after_iret = in_svc & ~vec_onehot(svc_idx);
  assign set_vec        = (sw_int_set ? sw_int_in : '0) | (ext_irq & ~irq_q);
  assign clr_vec        = ack_fire ? vec_onehot(vec_q) : '0;
  assign latch_vec      = (state != ST_REQ) && (state_nxt == ST_REQ);

`ifdef INT_NEST_EN
  // Only a strictly higher-priority (lower-index) bit may interrupt service.
  assign preempt = win_any && (win_idx < svc_idx);
`else
  assign preempt = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (win_any) state_nxt = ST_REQ;
      ST_REQ:     if (int_ack) state_nxt = ST_SERVICE;
      ST_SERVICE: begin
        if (iret_fire) begin
          if (svc_after_iret == '0) state_nxt = ST_IDLE;
        end else if (preempt) begin
          state_nxt = ST_REQ;
        end
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: the request is exactly the REQ state, the vector is latched.
  always_comb begin
    int_req = (state == ST_REQ);
    int_vec = vec_q;
  end

  // Edge detector history, pending register and enable mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      irq_q   <= ext_irq;
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_wr_en) mask <= mask_wr_data;
    end
  end

  // Vector latch and in-service bitmap (set on ack, lowest bit popped on iret).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= '0;
      in_svc <= '0;
    end else begin
      if (latch_vec) vec_q <= win_idx;
      if (ack_fire)       in_svc <= in_svc | vec_onehot(vec_q);
      else if (iret_fire) in_svc <= svc_after_iret;
    end
  end

  assign pending_out = pending;
  assign in_service  = in_svc;
  assign mask_out    = mask;

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl. Expected vectors are queued when an
// interrupt event is driven and popped when the controller requests it.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             sw_int_set;
  logic [N_IRQ-1:0] sw_int_in;
  logic [N_IRQ-1:0] ext_irq;
  logic             iret;
  logic             mask_wr_en;
  logic [N_IRQ-1:0] mask_wr_data;
  logic             int_ack;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic [N_IRQ-1:0] pending_out;
  logic [N_IRQ-1:0] in_service;
  logic [N_IRQ-1:0] mask_out;

  int checks   = 0;
  int failures = 0;
  logic [VEC_W-1:0] exp_q[$];

  int_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw_int_set   (sw_int_set),
    .sw_int_in    (sw_int_in),
    .ext_irq      (ext_irq),
    .iret         (iret),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .int_ack      (int_ack),
    .int_req      (int_req),
    .int_vec      (int_vec),
    .pending_out  (pending_out),
    .in_service   (in_service),
    .mask_out     (mask_out)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N_IRQ-1:0] bit_of(input int v);
    logic [N_IRQ-1:0] one;
    one = 1;
    return one << v;
  endfunction

  task automatic sw_fire(input logic [N_IRQ-1:0] v);
    sw_int_set = 1'b1;
    sw_int_in  = v;
    tick();
    sw_int_set = 1'b0;
    sw_int_in  = '0;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_iret();
    iret = 1'b1;
    tick();
    iret = 1'b0;
  endtask

  task automatic write_mask(input logic [N_IRQ-1:0] m);
    mask_wr_en   = 1'b1;
    mask_wr_data = m;
    tick();
    mask_wr_en   = 1'b0;
    mask_wr_data = '0;
  endtask

  // Wait (bounded) for a request, then score its vector against the queue.
  task automatic wait_req(input string tag, input int budget);
    for (int i = 0; i < budget && !int_req; i++) tick();
    check_eq({tag, "_req"}, {31'd0, int_req}, 32'd1);
    if (int_req) begin
      if (exp_q.size() == 0) check_eq({tag, "_exp_avail"}, 32'd0, 32'd1);
      else check_eq({tag, "_vec"}, {27'd0, int_vec}, {27'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [VEC_W-1:0] rv;
    rst_n        = 1'b1;
    sw_int_set   = 1'b0;
    sw_int_in    = '0;
    ext_irq      = '0;
    iret         = 1'b0;
    mask_wr_en   = 1'b0;
    mask_wr_data = '0;
    int_ack      = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_req",     {31'd0, int_req}, 32'd0);
    check_eq("rst_vec",     {27'd0, int_vec}, 32'd0);
    check_eq("rst_pending", pending_out, 32'd0);
    check_eq("rst_insvc",   in_service, 32'd0);
    check_eq("rst_mask",    mask_out, 32'hFFFF_FFFF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 1: software interrupt 4, exact latency
    exp_q.push_back(5'd4);
    sw_fire(32'h0000_0010);
    check_eq("t1_pending", pending_out, 32'h10);
    check_eq("t1_no_req_yet", {31'd0, int_req}, 32'd0);
    tick();
    wait_req("t1", 0);
    do_ack();
    check_eq("t1_ack_pending", pending_out, 32'd0);
    check_eq("t1_ack_insvc", in_service, 32'h10);
    check_eq("t1_ack_req", {31'd0, int_req}, 32'd0);
    do_iret();
    check_eq("t1_iret_insvc", in_service, 32'd0);
    check_eq("t1_iret_state", {30'd0, dut.state}, {30'd0, ST_IDLE});

    // 2: two external edges together, then a held line
    exp_q.push_back(5'd3);
    exp_q.push_back(5'd7);
    ext_irq = 32'h88;
    tick();
    check_eq("t2_pending", pending_out, 32'h88);
    tick();
    wait_req("t2a", 0);
    do_ack();
    check_eq("t2_pending_after_ack", pending_out, 32'h80);
    check_eq("t2_insvc", in_service, 32'h8);
    do_iret();
    tick();
    wait_req("t2b", 0);
    do_ack();
    do_iret();
    tick();
    tick();
    check_eq("t2_held_pending", pending_out, 32'd0);
    check_eq("t2_held_req", {31'd0, int_req}, 32'd0);
    ext_irq = '0;
    tick();

    // 3: masked pending, then unmask
    write_mask(32'hFFFF_FFF7);
    check_eq("t3_mask", mask_out, 32'hFFFF_FFF7);
    ext_irq = 32'h8;
    tick();
    tick();
    tick();
    check_eq("t3_pending", pending_out, 32'h8);
    check_eq("t3_masked_req", {31'd0, int_req}, 32'd0);
    exp_q.push_back(5'd3);
    write_mask(32'hFFFF_FFFF);
    check_eq("t3_unmask_req_early", {31'd0, int_req}, 32'd0);
    tick();
    wait_req("t3", 0);
    do_ack();
    do_iret();
    ext_irq = '0;
    tick();

    // 4: set and clear of the same bit in the ack cycle
    exp_q.push_back(5'd5);
    sw_fire(32'h20);
    tick();
    wait_req("t4a", 0);
    int_ack    = 1'b1;
    sw_int_set = 1'b1;
    sw_int_in  = 32'h20;
    tick();
    int_ack    = 1'b0;
    sw_int_set = 1'b0;
    sw_int_in  = '0;
    check_eq("t4_pending", pending_out, 32'h20);
    check_eq("t4_insvc", in_service, 32'h20);
    tick();
    check_eq("t4_no_req_in_service", {31'd0, int_req}, 32'd0);
    exp_q.push_back(5'd5);
    do_iret();
    tick();
    wait_req("t4b", 0);
    do_ack();
    do_iret();

    // 5: higher-priority event while servicing vector 9
    exp_q.push_back(5'd9);
    sw_fire(bit_of(9));
    tick();
    wait_req("t5a", 0);
    do_ack();
    check_eq("t5_insvc9", in_service, 32'h200);
    exp_q.push_back(5'd2);
    ext_irq = 32'h4;
    tick();
    tick();
`ifdef INT_NEST_EN
    wait_req("t5_nest", 0);
    do_ack();
    check_eq("t5_nest_insvc", in_service, 32'h204);
    do_iret();
    check_eq("t5_nest_iret1", in_service, 32'h200);
    do_iret();
    check_eq("t5_nest_iret2", in_service, 32'd0);
`else
    tick();
    check_eq("t5_flat_no_req", {31'd0, int_req}, 32'd0);
    check_eq("t5_flat_pending", pending_out, 32'h4);
    do_iret();
    check_eq("t5_flat_iret", in_service, 32'd0);
    tick();
    wait_req("t5_flat", 0);
    do_ack();
    do_iret();
`endif
    ext_irq = '0;
    tick();

    // 6: reset while busy
    exp_q.push_back(5'd1);
    sw_fire(bit_of(1));
    tick();
    wait_req("t6a", 0);
    do_ack();
`ifdef INT_NEST_EN
    exp_q.push_back(5'd0);
    sw_fire(bit_of(0));
    tick();
    wait_req("t6_nest", 0);
`else
    sw_fire(bit_of(0));
`endif
    write_mask(32'h0);
    check_eq("t6_busy_insvc", in_service, 32'h2);
    rst_n = 1'b0;
    #2;
    check_eq("t6_rst_req",     {31'd0, int_req}, 32'd0);
    check_eq("t6_rst_pending", pending_out, 32'd0);
    check_eq("t6_rst_insvc",   in_service, 32'd0);
    check_eq("t6_rst_mask",    mask_out, 32'hFFFF_FFFF);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check_eq("t6_post_req", {31'd0, int_req}, 32'd0);
    check_eq("t6_post_pending", pending_out, 32'd0);

    // random single software interrupts
    for (int k = 0; k < 8; k++) begin
      rv = VEC_W'($urandom_range(0, N_IRQ - 1));
      exp_q.push_back(rv);
      sw_fire(bit_of(int'(rv)));
      wait_req("rnd", 4);
      do_ack();
      check_eq("rnd_insvc", in_service, bit_of(int'(rv)));
      do_iret();
      check_eq("rnd_iret", in_service, 32'd0);
    end

    check_eq("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
